// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle for dcache; the cache attaches through the slave modport.
interface dcache_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned ADDR  = 32
);
  logic [ADDR-1:0]  cpu_addr;
  logic [31:0]      cpu_wdata;
  logic             cpu_read;
  logic             cpu_write;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_write;
  logic             mem_read;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata,
    output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped line cache between the memory stage and line-wide memory.
// DCACHE_WRITEBACK_EN selects write-back with dirty lines; undefined gives write-through.
module dcache #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus
);
  localparam int unsigned WB = $clog2(WIDTH / 8);
  localparam int unsigned DB = $clog2(DEPTH);
  localparam int unsigned SW = WB - 2;
  localparam int unsigned TW = ADDR - DB - WB;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WBACK = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] WTHRU = 2'd3;

  logic [1:0]       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] line_q [DEPTH];
  logic [TW-1:0]    tag_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [31:0]      rdata_q;
  logic             mem_read_q, mem_write_q;
  logic [ADDR-1:0]  mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;

  logic [SW-1:0]    sel;
  logic [DB-1:0]    idx;
  logic [TW-1:0]    tag;
  logic             req, hit, last;
  logic             load_hit, store_hit, store_commit, wt_block, victim_dirty;
  logic [WIDTH-1:0] cur_line, merged_line;
  logic [31:0]      word;
  logic             stall_c;
  logic [31:0]      rdata_c;
  logic             unused_addr_bits;

  assign sel = bus.cpu_addr[WB-1:2];
  assign idx = bus.cpu_addr[DB+WB-1:WB];
  assign tag = bus.cpu_addr[ADDR-1:DB+WB];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign req       = bus.cpu_read | bus.cpu_write;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign last      = (cnt == CW'(LATENCY - 1));
  assign cur_line  = line_q[idx];
  assign word      = cur_line[{sel, 5'b0} +: 32];
  assign load_hit  = (state == IDLE) && bus.cpu_read && !bus.cpu_write && hit;
  assign store_hit = (state == IDLE) && bus.cpu_write && hit;

`ifdef DCACHE_WRITEBACK_EN
  logic [DEPTH-1:0] dirty_q;
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign wt_block     = 1'b0;
  assign store_commit = store_hit;
`else
  logic wt_done;
  assign victim_dirty = 1'b0;
  assign wt_block     = store_hit && !wt_done;
  assign store_commit = store_hit && wt_done;
`endif

  // Requested word spliced into the resident line
  always_comb begin
    merged_line = cur_line;
    merged_line[{sel, 5'b0} +: 32] = bus.cpu_wdata;
  end

  // Next state plus the combinational CPU-side handshake
  always_comb begin
    state_next = state;
    stall_c    = (state != IDLE) || (req && !hit) || wt_block;
    rdata_c    = rdata_q;
    if (load_hit) rdata_c = word;
    case (state)
      IDLE: begin
        if (req && !hit)   state_next = victim_dirty ? WBACK : FILL;
        else if (wt_block) state_next = WTHRU;
      end
      WBACK:   if (last) state_next = FILL;
      FILL:    if (last) state_next = IDLE;
      WTHRU:   if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.cpu_stall = stall_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Control state, memory strobes and per-line status bits
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      valid_q     <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef DCACHE_WRITEBACK_EN
      dirty_q     <= '0;
`else
      wt_done     <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      cnt         <= (state_next != state || state == IDLE) ? '0 : cnt + CW'(1);
      mem_read_q  <= (state_next == FILL);
      mem_write_q <= (state_next == WBACK) || (state_next == WTHRU);
      if (state_next != state) begin
        case (state_next)
          WBACK: begin
            mem_addr_q  <= {tag_q[idx], idx, {WB{1'b0}}};
            mem_wdata_q <= cur_line;
          end
          FILL:  mem_addr_q <= {tag, idx, {WB{1'b0}}};
          WTHRU: begin
            mem_addr_q  <= {tag, idx, {WB{1'b0}}};
            mem_wdata_q <= merged_line;
          end
          default: ;
        endcase
      end
      if (load_hit) rdata_q <= word;
      if (state == FILL && last) valid_q[idx] <= 1'b1;
`ifdef DCACHE_WRITEBACK_EN
      if ((state == FILL || state == WBACK) && last) dirty_q[idx] <= 1'b0;
      else if (store_commit)                         dirty_q[idx] <= 1'b1;
`else
      if (state == WTHRU && last) wt_done <= 1'b1;
      else if (store_commit)      wt_done <= 1'b0;
`endif
    end
  end

  // Line data and tags need no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FILL && last) begin
        line_q[idx] <= bus.mem_rdata;
        tag_q[idx]  <= tag;
      end else if (store_commit) begin
        line_q[idx] <= merged_line;
      end
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed steps then random loads/stores against a transaction-level cache model.
module tb_dcache;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ADDR  = 32;
  localparam int unsigned L     = 2;
`ifdef DCACHE_WRITEBACK_EN
  localparam bit WBM = 1'b1;
`else
  localparam bit WBM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic load_mem;
  always #5 clk = ~clk;

  dcache_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();
  dcache #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Backing memory: 64 lines covering byte addresses 0x000-0x3FF
  logic [127:0] mem_tb  [64];
  logic [127:0] mem_exp [64];
  assign bus.mem_rdata = mem_tb[bus.mem_addr[9:4]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem_tb[i] <= mem_exp[i];
    end else if (bus.mem_write) begin
      mem_tb[bus.mem_addr[9:4]] <= bus.mem_wdata;
    end
  end

  // Reference cache contents
  logic         m_valid [4];
  logic         m_dirty [4];
  logic [25:0]  m_tag   [4];
  logic [127:0] m_line  [4];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One CPU request: model predicts stalls, memory traffic and load data; called at a negedge
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got);
    logic [1:0]  idx;
    logic [25:0] tg;
    logic [5:0]  ln;
    int          s, exp_stall, exp_rc, exp_wc, stalls, rc, wc, bad, both;
    logic [31:0] exp_ra, exp_wa, exp_rd;
    bit          done;
    idx = addr[5:4];
    tg  = addr[31:6];
    ln  = addr[9:4];
    s   = int'(addr[3:2]);
    exp_stall = 0; exp_rc = 0; exp_wc = 0;
    exp_ra = 32'hFFFF_FFFF; exp_wa = 32'hFFFF_FFFF; exp_rd = 32'h0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (WBM && m_valid[idx] && m_dirty[idx]) begin
        exp_stall += L;
        exp_wc    += L;
        exp_wa     = {m_tag[idx], idx, 4'b0};
        mem_exp[{m_tag[idx][3:0], idx}] = m_line[idx];
      end
      exp_stall += L + 1;
      exp_rc    += L;
      exp_ra     = {tg, idx, 4'b0};
      m_line[idx]  = mem_exp[ln];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_line[idx][s*32 +: 32] = wd;
      if (WBM) m_dirty[idx] = 1'b1;
      else begin
        exp_stall += L + 1;
        exp_wc    += L;
        exp_wa     = {tg, idx, 4'b0};
        mem_exp[ln] = m_line[idx];
      end
    end else begin
      exp_rd = m_line[idx][s*32 +: 32];
    end

    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    bus.cpu_read = rd;
    bus.cpu_write = wr;
    stalls = 0; rc = 0; wc = 0; bad = 0; both = 0; done = 1'b0; got = 32'h0;
    #1;
    while (!done) begin
      if (bus.mem_read) begin
        rc++;
        if (bus.mem_addr !== exp_ra) bad++;
      end
      if (bus.mem_write) begin
        wc++;
        if (bus.mem_addr !== exp_wa) bad++;
      end
      if (bus.mem_read && bus.mem_write) both++;
      if (!bus.cpu_stall) begin
        done = 1'b1;
        got = bus.cpu_rdata;
      end else begin
        stalls++;
        if (stalls > 4 * L + 10) done = 1'b1;
        else begin
          @(negedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    #1;
    check("stall_cycles", 128'(stalls), 128'(exp_stall));
    check("mem_read_cycles", 128'(rc), 128'(exp_rc));
    check("mem_write_cycles", 128'(wc), 128'(exp_wc));
    check("mem_addr", 128'(bad), 128'(0));
    check("strobes_exclusive", 128'(both), 128'(0));
    if (!wr) begin
      check("load_data", 128'(got), 128'(exp_rd));
      check("rdata_hold", 128'(bus.cpu_rdata), 128'(exp_rd));
    end
  endtask

  logic [31:0] got;
  logic [31:0] a;
  int          op;

  initial begin
    for (int i = 0; i < 64; i++) mem_exp[i] = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    load_mem = 1'b1;
    reset = 1'b1;
    bus.cpu_addr = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mem_read", 128'(bus.mem_read), 128'(0));
    check("rst_mem_write", 128'(bus.mem_write), 128'(0));
    check("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    check("rst_mem_wdata", bus.mem_wdata, 128'(0));
    check("rst_cpu_rdata", 128'(bus.cpu_rdata), 128'(0));
    check("rst_cpu_stall", 128'(bus.cpu_stall), 128'(0));
    @(negedge clk);

    // Clean miss then neighbouring-word hit
    access(1'b0, 1'b1, 32'h10, 32'h0, got);
    check("first_load_word0", 128'(got), 128'(mem_exp[1][31:0]));
    access(1'b0, 1'b1, 32'h14, 32'h0, got);
    check("hit_load_word1", 128'(got), 128'(mem_exp[1][63:32]));

    // Store then conflicting load: eviction (write-back) or earlier write-through lands in memory
    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, got);
    access(1'b0, 1'b1, 32'h50, 32'h0, got);
    check("evicted_word", 128'(mem_tb[1][31:0]), 128'(32'hDEADBEEF));

    // Read and write together act as a store
    access(1'b1, 1'b1, 32'h54, 32'h12345678, got);
    access(1'b0, 1'b1, 32'h54, 32'h0, got);
    check("rw_both_store", 128'(got), 128'(32'h12345678));

    // Reset in the middle of a fill
    do_reset();
    bus.cpu_addr = 32'h20;
    bus.cpu_read = 1'b1;
    @(negedge clk);
    #1;
    check("fill_strobe_up", 128'(bus.mem_read), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_mem_read", 128'(bus.mem_read), 128'(0));
    check("abort_mem_write", 128'(bus.mem_write), 128'(0));
    reset = 1'b0;
    bus.cpu_read = 1'b0;
    model_reset();
    @(negedge clk);
    access(1'b0, 1'b1, 32'h20, 32'h0, got);

    // Random traffic over 16 tags x 4 indices
    repeat (250) begin
      a  = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      op = $urandom_range(0, 3);
      access(op >= 2, op != 2, a, $urandom, got);
    end

    for (int i = 0; i < 64; i++) check("memory_image", mem_tb[i], mem_exp[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
